// File: rtl/zimbo_memsys.sv
// zimbo_memsys: word RAM, MMIO page (GPIO/timer/status) and a
// byte-stream loader that owns the RAM and stalls the core while it runs.
module zimbo_memsys #(
  parameter int          AW        = 8,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addrm,
  input  logic [15:0] wmdata,
  input  logic        memwr_en,
  output logic [15:0] rmdata,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_hold,
  output logic        timer_irq,
  output logic [15:0] gpio_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_DONE
  } ld_state_e;

  ld_state_e     state_q, state_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [7:0]    hi_q, hi_d;
  logic          ld_we;
  logic [15:0]   ld_wdata;

  logic [15:0]   gpio_q, gpio_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   cmp_q, cmp_d;
  logic          en_q, en_d;
  logic          flag_q, flag_d;

  logic [15:0]   mem [2**AW];

  logic [15:0]   off;
  logic          is_ram, is_io;
  logic          cw;
  logic          wr_gpio, wr_count, wr_cmp, wr_stat;
  logic          run, match;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [15:0]   ram_wdata;

  assign off    = addrm - MMIO_BASE;
  assign is_ram = addrm < MMIO_BASE;
  assign is_io  = !is_ram && (off[15:4] == 12'h000);

  assign cw       = memwr_en & ~core_hold;
  assign wr_gpio  = cw & is_io & (off[3:0] == 4'd0);
  assign wr_count = cw & is_io & (off[3:0] == 4'd1);
  assign wr_cmp   = cw & is_io & (off[3:0] == 4'd2);
  assign wr_stat  = cw & is_io & (off[3:0] == 4'd3);

  assign core_hold = (state_q != S_IDLE);
  assign ld_ready  = (state_q == S_HI) || (state_q == S_LO);
  assign timer_irq = flag_q;
  assign gpio_out  = gpio_q;

  always_comb begin
    rmdata = 16'h0000;
    unique case (1'b1)
      is_ram: rmdata = mem[addrm[AW-1:0]];
      is_io: begin
        case (off[3:0])
          4'd0:    rmdata = gpio_q;
          4'd1:    rmdata = count_q;
          4'd2:    rmdata = cmp_q;
          4'd3:    rmdata = {14'h0000, en_q, flag_q};
          default: rmdata = 16'h0000;
        endcase
      end
      default: rmdata = 16'h0000;
    endcase
  end

  // The timer freezes while the loader holds the core.
  assign run   = en_q & ~core_hold;
  assign match = run & (count_q == cmp_q);

  always_comb begin
    count_d = count_q;
    if (match)
      count_d = 16'h0000;
    else if (run)
      count_d = count_q + 16'd1;
    if (wr_count)
      count_d = wmdata;
    flag_d = match | (flag_q & ~(wr_stat & wmdata[0]));
    en_d   = wr_stat ? wmdata[1] : en_q;
    gpio_d = wr_gpio ? wmdata : gpio_q;
    cmp_d  = wr_cmp ? wmdata : cmp_q;
  end

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    hi_d      = hi_q;
    ld_we     = 1'b0;
    ld_wdata  = 16'h0000;
    unique case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          ld_addr_d = '0;
          state_d   = S_HI;
        end
      end
      S_HI: begin
        if (ld_valid) begin
          hi_d = ld_byte;
          if (ld_last) begin
            ld_we    = 1'b1;
            ld_wdata = {ld_byte, 8'h00};
            state_d  = S_DONE;
          end else begin
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (ld_valid) begin
          ld_we     = 1'b1;
          ld_wdata  = {hi_q, ld_byte};
          ld_addr_d = ld_addr_q + AW'(1);
          state_d   = ld_last ? S_DONE : S_HI;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ld_addr_q <= '0;
      hi_q      <= 8'h00;
      gpio_q    <= 16'h0000;
      count_q   <= 16'h0000;
      cmp_q     <= 16'hFFFF;
      en_q      <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      hi_q      <= hi_d;
      gpio_q    <= gpio_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      en_q      <= en_d;
      flag_q    <= flag_d;
    end
  end

  // A reset edge aborts any in-flight word; RAM itself keeps its contents.
  assign ram_we    = (ld_we | (cw & is_ram)) & ~reset;
  assign ram_waddr = ld_we ? ld_addr_q : addrm[AW-1:0];
  assign ram_wdata = ld_we ? ld_wdata : wmdata;

  always_ff @(posedge clock) begin
    if (ram_we)
      mem[ram_waddr] <= ram_wdata;
  end

endmodule
